// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : serial_subtractor_pkg                                       |
// | Brief  : FSM state encoding and sizing helper for the subtractor     |
// | Rev    : 1.0 initial release                                         |
// +----------------------------------------------------------------------+
package serial_subtractor_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold reglength-1 even when reglength is 1.
    function automatic int cnt_width(input int len);
        return $clog2(len) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : serial_subtractor_if                                        |
// | Brief  : operand/result handshake bundle for the serial subtractor   |
// | Rev    : 1.0 initial release                                         |
// +----------------------------------------------------------------------+
interface serial_subtractor_if #(
    parameter int REGLENGTH = 3
);
    logic                 start;
    logic [REGLENGTH-1:0] r1;
    logic [REGLENGTH-1:0] r2;
    logic                 busy;
    logic                 done;
    logic [REGLENGTH-1:0] diff;
    logic                 borrow;

    modport master (output start, r1, r2, input busy, done, diff, borrow);
    modport slave  (input start, r1, r2, output busy, done, diff, borrow);
endinterface
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor_bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : full_subtractor_bit                                         |
// | Brief  : one-bit full subtractor, d = a - b - bin                    |
// | Rev    : 1.0 initial release                                         |
// +----------------------------------------------------------------------+
module full_subtractor_bit (
    input  wire logic a,
    input  wire logic b,
    input  wire logic bin,
    output logic      d,
    output logic      bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : serial_subtractor                                           |
// | Brief  : bit-serial r1 - r2, LSB first, start/busy/done handshake    |
// | Rev    : 1.0 initial release                                         |
// +----------------------------------------------------------------------+
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int REGLENGTH = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    serial_subtractor_if.slave bus
);
    localparam int                c_CNT_W = cnt_width(REGLENGTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(REGLENGTH - 1);

    state_t               r_state;
    state_t               w_next;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_accept;
    logic                 w_last;
    logic [REGLENGTH-1:0] r_a;
    logic [REGLENGTH-1:0] r_b;
    logic [REGLENGTH-1:0] r_acc;
    logic [REGLENGTH-1:0] w_acc_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_bw;
    logic                 w_d;
    logic                 w_bout;
    logic [REGLENGTH-1:0] r_diff;
    logic                 r_borrow;

    full_subtractor_bit u_fsb (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bw),
        .d    (w_d),
        .bout (w_bout)
    );

    generate
        if (REGLENGTH == 1) begin : g_acc_single
            assign w_acc_next = w_d;
        end else begin : g_acc_multi
            assign w_acc_next = {w_d, r_acc[REGLENGTH-1:1]};
        end
    endgenerate

    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = bus.start;
                if (bus.start) w_next = ST_RUN;
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done   = 1'b1;
                w_accept = bus.start;
                w_next   = bus.start ? ST_RUN : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Results only change on the final RUN edge, so they stay stable across back-to-back runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_bw     <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_a   <= bus.r1;
            r_b   <= bus.r2;
            r_acc <= '0;
            r_cnt <= '0;
            r_bw  <= 1'b0;
        end else if (w_busy) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_acc <= w_acc_next;
            r_bw  <= w_bout;
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
                r_diff   <= w_acc_next;
                r_borrow <= w_bout;
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_serial_subtractor                                        |
// | Brief  : directed self-checking bench for serial_subtractor          |
// | Rev    : 1.0 initial release                                         |
// +----------------------------------------------------------------------+
module tb_serial_subtractor;
    localparam int REGLENGTH = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    serial_subtractor_if #(.REGLENGTH(REGLENGTH)) bus ();

    serial_subtractor #(.REGLENGTH(REGLENGTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #1 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts an operation from IDLE/DONE, scrambles the operands after capture, waits for done.
    task automatic run_op(input int a, input int b, output int lat, output int nbusy);
        bus.start = 1'b1;
        bus.r1    = a[REGLENGTH-1:0];
        bus.r2    = b[REGLENGTH-1:0];
        @(negedge clk);
        bus.start = 1'b0;
        bus.r1    = ~a[REGLENGTH-1:0];
        bus.r2    = ~b[REGLENGTH-1:0];
        lat   = 0;
        nbusy = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check("done_timeout", {31'd0, bus.done}, 32'd1);
    endtask

    int da  [4] = '{5, 3, 0, 7};
    int db  [4] = '{3, 5, 1, 7};
    int dd  [4] = '{2, 6, 7, 0};
    int dbw [4] = '{0, 1, 1, 0};
    int ca  [5] = '{1, 6, 4, 2, 7};
    int cb  [5] = '{2, 1, 4, 7, 0};

    initial begin
        int lat;
        int nbusy;
        int gap;
        int seen;
        int pa;
        int pb;

        bus.start = 1'b0;
        bus.r1    = '0;
        bus.r2    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   {31'd0, bus.busy},   32'd0);
        check("rst_done",   {31'd0, bus.done},   32'd0);
        check("rst_diff",   {29'd0, bus.diff},   32'd0);
        check("rst_borrow", {31'd0, bus.borrow}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-computed results.
        for (int i = 0; i < 4; i++) begin
            run_op(da[i], db[i], lat, nbusy);
            check("dir_latency", lat,   3);
            check("dir_busy",    nbusy, 3);
            check("dir_diff",    {29'd0, bus.diff},   dd[i]);
            check("dir_borrow",  {31'd0, bus.borrow}, dbw[i]);
            @(negedge clk);
            check("dir_done_1cyc", {31'd0, bus.done}, 32'd0);
        end

        // Exhaustive sweep plus round trip through an adder model.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                run_op(a, b, lat, nbusy);
                check("sweep_diff",   {29'd0, bus.diff},   (a - b) & 7);
                check("sweep_borrow", {31'd0, bus.borrow}, (a < b) ? 1 : 0);
                check("sweep_sum",    (int'(bus.diff) + b) & 7, a);
                @(negedge clk);
            end
        end

        // start held high: new operands are presented at each DONE edge.
        bus.start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pa     = ca[k];
            pb     = cb[k];
            bus.r1 = pa[REGLENGTH-1:0];
            bus.r2 = pb[REGLENGTH-1:0];
            @(negedge clk);
            bus.r1 = ~pa[REGLENGTH-1:0];
            bus.r2 = ~pb[REGLENGTH-1:0];
            gap = 1;
            while (!bus.done && gap < 20) begin
                @(negedge clk);
                gap++;
            end
            check("b2b_gap",    gap, 4);
            check("b2b_diff",   {29'd0, bus.diff},   (pa - pb) & 7);
            check("b2b_borrow", {31'd0, bus.borrow}, (pa < pb) ? 1 : 0);
        end
        bus.start = 1'b0;
        @(negedge clk);
        check("b2b_idle", {31'd0, bus.busy}, 32'd0);

        // start re-pulsed mid-RUN must not re-capture.
        bus.start = 1'b1;
        bus.r1    = 3'd6;
        bus.r2    = 3'd2;
        @(negedge clk);
        bus.r1 = 3'd1;
        bus.r2 = 3'd7;
        @(negedge clk);
        bus.start = 1'b0;
        bus.r1    = 3'd0;
        bus.r2    = 3'd0;
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("midrun_latency", lat, 2);
        check("midrun_diff",    {29'd0, bus.diff},   32'd4);
        check("midrun_borrow",  {31'd0, bus.borrow}, 32'd0);
        @(negedge clk);

        // Reset in the 2nd RUN cycle aborts and clears results.
        bus.start = 1'b1;
        bus.r1    = 3'd5;
        bus.r2    = 3'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("abort_in_run", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy",   {31'd0, bus.busy},   32'd0);
        check("abort_done",   {31'd0, bus.done},   32'd0);
        check("abort_diff",   {29'd0, bus.diff},   32'd0);
        check("abort_borrow", {31'd0, bus.borrow}, 32'd0);
        reset = 1'b0;
        seen  = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1;
        end
        check("abort_no_done", seen, 0);

        // reset and start on the same edge: start is dropped.
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.r1    = 3'd5;
        bus.r2    = 3'd3;
        @(negedge clk);
        check("rst_start_busy", {31'd0, bus.busy}, 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_start_dropped", {31'd0, bus.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
